mem_access_ctrl: RTL and testbench

//  Sequences every data-memory access of the core through a word-wide memory with an ack handshake.

---
 rtl/mem_ctrl_pkg.sv | 20 ++
 rtl/store_merge.sv | 25 ++
 rtl/mem_access_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
//   state_t    : FSM state encoding (IDLE, RD, WR, DONE)
//   cnt_width  : width of the timeout counter for a given TIMEOUT value
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int TIMEOUT_DEFAULT = 16;

    // The counter only has to reach TIMEOUT-1, so $clog2(TIMEOUT) bits are enough.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/store_merge.sv
// Byte-lane merge used for read-modify-write byte stores.
// Ports:
//   word   in  32  word read from memory
//   byte_v in  8   byte to insert
//   off    in  2   byte lane (00 -> [7:0] ... 11 -> [31:24])
//   merged out 32  word with the selected lane replaced
module store_merge (
    input  logic [31:0] word,
    input  logic [7:0]  byte_v,
    input  logic [1:0]  off,
    output logic [31:0] merged
);

    always_comb begin
        merged = word;
        case (off)
            2'b00: merged[7:0]   = byte_v;
            2'b01: merged[15:8]  = byte_v;
            2'b10: merged[23:16] = byte_v;
            2'b11: merged[31:24] = byte_v;
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer for the core.
// Loads return the raw memory word plus the latched offset/DT/Sign controls
// for the downstream load-extend logic; byte stores are read-modify-write.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req_valid/we/addr/wdata/dt/sign  core request (sampled only in IDLE)
//   stall                         hold core pipeline while an access is in flight
//   done                          one-cycle pulse, ld_* valid
//   err                           one-cycle pulse: misaligned word access or timeout
//   ld_word/ld_off/ld_dt/ld_sign  load result and latched controls
//   mem_req/we/addr/wdata         memory request side
//   mem_rdata/mem_ack             memory response side
// Handshake: mem_req is raised with mem_addr/mem_we/mem_wdata stable and held
// until a cycle in which mem_ack=1 (the transfer completes at that rising
// edge); mem_ack is ignored whenever mem_req=0. If TIMEOUT request cycles pass
// without ack, the request is withdrawn and the access ends with done=err=1.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_dt,
    input  logic        req_sign,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] ld_word,
    output logic [1:0]  ld_off,
    output logic        ld_dt,
    output logic        ld_sign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int            CW   = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          we_q;
    logic          accept;
    logic          misaligned;
    logic          tmo;
    logic          err_d;
    logic [31:0]   merged;

    // Timeout fires only when the last allowed cycle passes without ack;
    // an ack in that same cycle takes priority.
    assign tmo = (cnt_q == TMAX) && !mem_ack;

    // The store byte was captured into mem_wdata[7:0] at accept time.
    store_merge u_merge (
        .word   (mem_rdata),
        .byte_v (mem_wdata[7:0]),
        .off    (ld_off),
        .merged (merged)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        done       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        accept     = 1'b0;
        misaligned = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_dt && (req_addr[1:0] != 2'b00)) begin
                        misaligned = 1'b1;
                        err_d      = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        stall   = 1'b1;
                        // Word store writes directly; loads and byte stores read first.
                        state_d = (req_we && req_dt) ? S_WR : S_RD;
                    end
                end
            end
            S_RD: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_d = (we_q && !ld_dt) ? S_WR : S_DONE;
                end else if (tmo) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_WR: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    state_d = S_DONE;
                end else if (tmo) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err       <= 1'b0;
            ld_word   <= 32'h0;
            ld_off    <= 2'b00;
            ld_dt     <= 1'b0;
            ld_sign   <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            err <= err_d;

            if (accept) begin
                mem_addr  <= {req_addr[31:2], 2'b00};
                mem_wdata <= req_wdata;
                ld_off    <= req_addr[1:0];
                ld_dt     <= req_dt;
                ld_sign   <= req_sign;
                we_q      <= req_we;
            end

            if (state_q == S_RD) begin
                if (mem_ack) begin
                    ld_word <= mem_rdata;
                    if (we_q && !ld_dt) mem_wdata <= merged;
                end else if (tmo) begin
                    ld_word <= 32'h0;
                end
            end else if (state_q == S_WR && !mem_ack && tmo) begin
                ld_word <= 32'h0;
            end

            // Counter is zero whenever no request is pending or one just
            // completed, so it starts from 0 on entering RD or WR.
            if (mem_req && !mem_ack) cnt_q <= cnt_q + CW'(1);
            else                     cnt_q <= '0;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 16;
    localparam int W = 38;  // {err, done, ld_word, ld_off, ld_dt, ld_sign}

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_dt = 1'b0;
    logic        req_sign = 1'b0;
    logic        stall, done, err;
    logic [31:0] ld_word;
    logic [1:0]  ld_off;
    logic        ld_dt, ld_sign;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_dt(req_dt), .req_sign(req_sign),
        .stall(stall), .done(done), .err(err),
        .ld_word(ld_word), .ld_off(ld_off), .ld_dt(ld_dt), .ld_sign(ld_sign),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0]  exp_q[$];
    logic [63:0]   wr_q[$];     // {word address, write data}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory (bench side) and reference memory ----------------
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    // Responder knobs, set by the driver before each request.
    int          rd_wait = 0;
    int          wr_wait = 0;
    logic        no_ack = 1'b0;
    logic        force_ack = 1'b0;
    logic [31:0] exp_addr = 32'h0;

    int          wait_left = 0;
    logic        in_phase = 1'b0;
    logic [31:0] sv_addr, sv_wdata;
    logic        sv_we;

    always @(negedge clk) begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (force_ack) begin
            mem_ack = 1'b1;
        end else if (!mem_req || reset) begin
            in_phase = 1'b0;
        end else begin
            if (!in_phase) begin
                in_phase  = 1'b1;
                wait_left = mem_we ? wr_wait : rd_wait;
                sv_addr   = mem_addr;
                sv_we     = mem_we;
                sv_wdata  = mem_wdata;
                check("mem_addr", {32'h0, mem_addr}, {32'h0, exp_addr});
            end else begin
                check("hold_addr",  {32'h0, mem_addr},  {32'h0, sv_addr});
                check("hold_we",    {63'h0, mem_we},    {63'h0, sv_we});
                check("hold_wdata", {32'h0, mem_wdata}, {32'h0, sv_wdata});
            end
            if (!no_ack) begin
                if (wait_left == 0) begin
                    mem_ack  = 1'b1;
                    in_phase = 1'b0;
                    if (mem_we) begin
                        if (wr_q.size() == 0) begin
                            check("unexpected_write", {mem_addr, mem_wdata}, 64'h0);
                        end else begin
                            check("write", {mem_addr, mem_wdata}, wr_q.pop_front());
                        end
                        mem[mem_addr[9:2]] = mem_wdata;
                    end else begin
                        mem_rdata = mem[mem_addr[9:2]];
                    end
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset && (done || err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {26'h0, err, done, ld_word, ld_off, ld_dt, ld_sign}, 64'h0);
            end else begin
                check("resp", {26'h0, err, done, ld_word, ld_off, ld_dt, ld_sign},
                      {26'h0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] last_word = 32'h0;
    logic [1:0]  last_off  = 2'b00;
    logic        last_dt   = 1'b0;
    logic        last_sign = 1'b0;

    task automatic model_reset();
        last_word = 32'h0;
        last_off  = 2'b00;
        last_dt   = 1'b0;
        last_sign = 1'b0;
    endtask

    // Returns the expected response and the number of negedges from the drive
    // to the done/err pulse; pushes any expected memory write.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic dt, input logic sign, input int rw, input int ww,
                         input logic noack_i, input logic push_it,
                         output logic [W-1:0] resp, output int lat);
        int          off;
        logic [31:0] old, mask, nw;
        off = int'(addr[1:0]);
        if (dt && off != 0) begin
            resp = {1'b1, 1'b0, last_word, last_off, last_dt, last_sign};
            lat  = 1;
            return;
        end
        old = ref_mem[addr[9:2]];
        if (noack_i) begin
            last_word = 32'h0;
            lat = TIMEOUT + 1;
        end else if (!we) begin
            last_word = old;
            lat = 2 + rw;
        end else if (dt) begin
            if (push_it) begin
                wr_q.push_back({addr & 32'hFFFF_FFFC, wdata});
                ref_mem[addr[9:2]] = wdata;
            end
            lat = 2 + ww;
        end else begin
            mask = 32'hFF << (8 * off);
            nw   = (old & ~mask) | ({24'h0, wdata[7:0]} << (8 * off));
            if (push_it) begin
                wr_q.push_back({addr & 32'hFFFF_FFFC, nw});
                ref_mem[addr[9:2]] = nw;
            end
            last_word = old;
            lat = 3 + rw + ww;
        end
        last_off  = addr[1:0];
        last_dt   = dt;
        last_sign = sign;
        resp = {noack_i, 1'b1, last_word, last_off, last_dt, last_sign};
    endtask

    // ---------------- driver ----------------
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic dt, input logic sign, input int rw, input int ww,
                          input logic noack_i, input logic abort);
        logic [W-1:0] resp;
        int           lat_exp, lat;
        logic         mis, seen;
        mis = dt && (addr[1:0] != 2'b00);
        model(we, addr, wdata, dt, sign, rw, ww, noack_i, !abort, resp, lat_exp);
        if (!abort) exp_q.push_back(resp);
        rd_wait  = rw;
        wr_wait  = ww;
        no_ack   = noack_i;
        exp_addr = {addr[31:2], 2'b00};
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_dt    = dt;
        req_sign  = sign;
        #1;
        check("stall_on_req", {63'h0, stall}, {63'h0, !mis});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = $urandom_range(0, 1);
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (abort) return;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 64) begin
            @(negedge clk);
            lat++;
            if (done || err) seen = 1'b1;
            else check("stall_busy", {63'h0, stall}, 64'h1);
        end
        if (!seen) begin
            check("resp_timeout", 64'(lat), 64'(lat_exp));
        end else begin
            check("latency", 64'(lat), 64'(lat_exp));
            check("stall_at_end", {63'h0, stall}, 64'h0);
            if (mis) check("mis_no_req", {63'h0, mem_req}, 64'h0);
        end
        no_ack = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_stall"},   {63'h0, stall},   64'h0);
        check({tag, "_done"},    {63'h0, done},    64'h0);
        check({tag, "_err"},     {63'h0, err},     64'h0);
        check({tag, "_mem_req"}, {63'h0, mem_req}, 64'h0);
        check({tag, "_mem_we"},  {63'h0, mem_we},  64'h0);
        check({tag, "_ld_word"}, {32'h0, ld_word}, 64'h0);
        check({tag, "_mem_addr"},  {32'h0, mem_addr},  64'h0);
        check({tag, "_mem_wdata"}, {32'h0, mem_wdata}, 64'h0);
        check({tag, "_ld_ctl"},  {60'h0, ld_off, ld_dt, ld_sign}, 64'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic        we, dt, sign, na;
        logic [31:0] addr;
        int          rw, ww;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[8'h40]     = 32'h80AB_CDEF;  ref_mem[8'h40] = 32'h80AB_CDEF;   // 0x100
        mem[8'hC0]     = 32'h1122_3344;  ref_mem[8'hC0] = 32'h1122_3344;   // 0x300

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        // Directed cases
        do_req(1'b0, 32'h103, 32'h0,         1'b0, 1'b0, 0, 0,  1'b0, 1'b0); // lb
        do_req(1'b1, 32'h200, 32'hDEAD_BEEF, 1'b1, 1'b0, 0, 3,  1'b0, 1'b0); // sw, 3 waits
        do_req(1'b1, 32'h302, 32'h0000_0055, 1'b0, 1'b0, 0, 0,  1'b0, 1'b0); // sb RMW
        do_req(1'b0, 32'h101, 32'h0,         1'b1, 1'b0, 0, 0,  1'b0, 1'b0); // misaligned lw
        do_req(1'b0, 32'h104, 32'h0,         1'b1, 1'b1, 15, 0, 1'b0, 1'b0); // ack on last cycle
        do_req(1'b0, 32'h108, 32'h0,         1'b1, 1'b0, 0, 0,  1'b1, 1'b0); // lw timeout

        // A late ack with no request outstanding must be ignored.
        @(negedge clk);
        force_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("late_ack_done",  {63'h0, done},  64'h0);
            check("late_ack_err",   {63'h0, err},   64'h0);
            check("late_ack_stall", {63'h0, stall}, 64'h0);
            check("late_ack_req",   {63'h0, mem_req}, 64'h0);
        end
        force_ack = 1'b0;

        do_req(1'b1, 32'h30D, 32'h0000_00A7, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);  // aborted sb, no write

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            we   = 1'($urandom_range(0, 1));
            dt   = 1'($urandom_range(0, 1));
            sign = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 1023));
            if (dt && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            rw = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
            ww = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
            na = ($urandom_range(0, 9) == 0);
            do_req(we, addr, $urandom, dt, sign, rw, ww, na, 1'b0);
        end

        // Reset during a word-store wait
        do_req(1'b1, 32'h3F0, 32'hCAFE_F00D, 1'b1, 1'b0, 0, 0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("wr_wait_req", {62'h0, mem_req, mem_we}, 64'h3);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midreset");
        reset  = 1'b0;
        no_ack = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check("post_reset_done", {63'h0, done}, 64'h0);
        end

        do_req(1'b0, 32'h3F0, 32'h0, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0);  // recovery load

        repeat (3) @(negedge clk);
        check("exp_q_empty", 64'(exp_q.size()), 64'h0);
        check("wr_q_empty",  64'(wr_q.size()),  64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
